// File: rtl/rs_serial_sec_decoder_pkg.sv
// Shared definitions for the serial RS(N,N-2) single-symbol-error decoder:
// FSM state type, default code size and the GF(2^M) multiply-by-alpha helper.
package rs_pkg;

    typedef enum logic [1:0] {IDLE, SYND, LOCATE, DONE} state_t;

    localparam int DEF_M = 3;
    localparam int DEF_N = 7;
    localparam int K     = DEF_N - 2;

    // Multiply an m-bit symbol by alpha (= x): shift left, reduce by the primitive polynomial.
    function automatic logic [15:0] gf_mul_alpha(input logic [15:0] sym, input int m,
                                                 input logic [15:0] poly);
        logic [15:0] res;
        logic [15:0] mask;
        mask = 16'hFFFF >> (16 - m);
        res  = sym << 1;
        if (sym[m-1]) begin
            res = res ^ poly;
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/rs_serial_sec_decoder_syndrome_acc.sv
// Symbol-serial syndrome accumulator: S0 = r(1), S1 = r(alpha) evaluated by Horner's rule,
// highest-degree symbol first.
import rs_pkg::*;

module rs_syndrome_acc #(
    parameter int         M         = 3,
    parameter logic [M:0] PRIM_POLY = 4'b1011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [M-1:0] sym,
    output logic [M-1:0] s0,
    output logic [M-1:0] s1
);

    logic [M-1:0] r_s0;
    logic [M-1:0] r_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (clr) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (en) begin
            r_s0 <= r_s0 ^ sym;
            r_s1 <= M'(gf_mul_alpha(16'(r_s1), M, 16'(PRIM_POLY))) ^ sym;
        end
    end

    assign s0 = r_s0;
    assign s1 = r_s1;

endmodule

// File: rtl/rs_serial_sec_decoder.sv
// Clocked RS(N,N-2) single-symbol-error-correcting decoder with valid/ready handshakes.
// Define RS_ERR_STATS_EN to add saturating corrected/uncorrectable word counters.
import rs_pkg::*;

module rs_serial_sec_decoder #(
    parameter int         M         = 3,
    parameter int         N         = 7,
    parameter logic [M:0] PRIM_POLY = 4'b1011
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*M-1:0] codeword,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*M-1:0] corrected,
    output logic           err_detected,
    output logic           uncorrectable
`ifdef RS_ERR_STATS_EN
    ,
    output logic [15:0]    corr_count,
    output logic [15:0]    uncorr_count
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         r_state;
    state_t         w_nextState;
    logic [N*M-1:0] r_buf;
    logic [N*M-1:0] r_corrected;
    logic [IW-1:0]  r_idx;
    logic [M-1:0]   r_p;
    logic           r_err;
    logic           r_unc;
    logic [M-1:0]   w_p;
    logic [M-1:0]   w_sym;
    logic [M-1:0]   w_s0;
    logic [M-1:0]   w_s1;
    logic           w_accept;
    logic           w_toDone;
    logic           w_err;
    logic           w_unc;
    logic           w_fix;
    logic           w_firstCycle;

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign w_accept     = in_valid && in_ready;
    assign w_sym        = r_buf[r_idx*M +: M];
    assign w_firstCycle = (r_idx == '0);

    rs_syndrome_acc #(.M(M), .PRIM_POLY(PRIM_POLY)) u_synd (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .en    (r_state == SYND),
        .sym   (w_sym),
        .s0    (w_s0),
        .s1    (w_s1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // LOCATE walks c upward; P_c starts at S0 and is multiplied by alpha every cycle.
    always_comb begin
        w_nextState = r_state;
        w_toDone    = 1'b0;
        w_err       = 1'b0;
        w_unc       = 1'b0;
        w_fix       = 1'b0;
        w_p         = w_firstCycle ? w_s0 : r_p;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = SYND;
                end
            end
            SYND: begin
                if (w_firstCycle) begin
                    w_nextState = LOCATE;
                end
            end
            LOCATE: begin
                if (w_firstCycle && (w_s0 == '0) && (w_s1 == '0)) begin
                    w_toDone = 1'b1;
                end else if (w_firstCycle && ((w_s0 == '0) != (w_s1 == '0))) begin
                    w_toDone = 1'b1;
                    w_err    = 1'b1;
                    w_unc    = 1'b1;
                end else if (w_p == w_s1) begin
                    w_toDone = 1'b1;
                    w_err    = 1'b1;
                    w_fix    = 1'b1;
                end else if (r_idx == IW'(N - 1)) begin
                    w_toDone = 1'b1;
                    w_err    = 1'b1;
                    w_unc    = 1'b1;
                end
                if (w_toDone) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // r_idx counts N-1 down to 0 during SYND, then 0 upward as the locator position c.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf       <= '0;
            r_idx       <= '0;
            r_p         <= '0;
            r_corrected <= '0;
            r_err       <= 1'b0;
            r_unc       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_buf <= codeword;
                        r_idx <= IW'(N - 1);
                    end
                end
                SYND: begin
                    if (!w_firstCycle) begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                LOCATE: begin
                    r_p <= M'(gf_mul_alpha(16'(w_p), M, 16'(PRIM_POLY)));
                    if (w_toDone) begin
                        r_corrected <= w_fix ? (r_buf ^ ((N*M)'(w_s0) << (r_idx*M))) : r_buf;
                        r_err       <= w_err;
                        r_unc       <= w_unc;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign corrected     = r_corrected;
    assign err_detected  = r_err;
    assign uncorrectable = r_unc;

`ifdef RS_ERR_STATS_EN
    logic [15:0] r_corrCount;
    logic [15:0] r_uncorrCount;

    // Counters only clear on reset and stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_corrCount   <= '0;
            r_uncorrCount <= '0;
        end else if (w_toDone) begin
            if (w_unc) begin
                if (r_uncorrCount != 16'hFFFF) begin
                    r_uncorrCount <= r_uncorrCount + 16'd1;
                end
            end else if (w_err) begin
                if (r_corrCount != 16'hFFFF) begin
                    r_corrCount <= r_corrCount + 16'd1;
                end
            end
        end
    end

    assign corr_count   = r_corrCount;
    assign uncorr_count = r_uncorrCount;
`endif

endmodule

// File: tb/tb_rs_serial_sec_decoder.sv
// Directed self-checking bench for rs_serial_sec_decoder at M=3, N=7, x^3+x+1.
// Expected words, flags and latencies are hand-derived from g(x)=(x+1)(x+2).
module tb_rs_serial_sec_decoder;

    localparam int          M = 3;
    localparam int          N = 7;
    localparam logic [20:0] V = 21'h00005A;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] codeword;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] corrected;
    logic        err_detected;
    logic        uncorrectable;
`ifdef RS_ERR_STATS_EN
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;
`endif

    int checkCount = 0;
    int passCount  = 0;

    rs_serial_sec_decoder #(.M(M), .N(N), .PRIM_POLY(4'b1011)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .codeword      (codeword),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .corrected     (corrected),
        .err_detected  (err_detected),
        .uncorrectable (uncorrectable)
`ifdef RS_ERR_STATS_EN
        ,
        .corr_count    (corr_count),
        .uncorr_count  (uncorr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a word and return #1 after the edge that accepts it.
    task automatic sendWord(input logic [20:0] word);
        int budget = 0;
        @(negedge clk);
        codeword = word;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("acceptReady", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input logic [20:0] expWord, input logic expErr,
                              input logic expUnc, input int expLat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".corrected"}, 32'(corrected), 32'(expWord));
        checkOutput({tag, ".err"}, 32'(err_detected), 32'(expErr));
        checkOutput({tag, ".unc"}, 32'(uncorrectable), 32'(expUnc));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".validDrop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".readyBack"}, 32'(in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [20:0] word,
                                 input logic [20:0] expWord, input logic expErr,
                                 input logic expUnc, input int expLat);
        sendWord(word);
        waitResult(tag, expWord, expErr, expUnc, expLat);
        drain(tag);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        codeword  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");
        checkOutput("rst.inReady", 32'(in_ready), 32'd1);
        checkOutput("rst.outValid", 32'(out_valid), 32'd0);
        checkOutput("rst.corrected", 32'(corrected), 32'd0);
        checkOutput("rst.err", 32'(err_detected), 32'd0);
        checkOutput("rst.unc", 32'(uncorrectable), 32'd0);

        applyStimulus("clean", V, V, 1'b0, 1'b0, 8);
        applyStimulus("errR4", V ^ (21'd5 << 12), V, 1'b1, 1'b0, 12);
        applyStimulus("errR0", V ^ 21'd7, V, 1'b1, 1'b0, 8);
        applyStimulus("errR6", V ^ (21'd1 << 18), V, 1'b1, 1'b0, 14);
        applyStimulus("s1Zero", V ^ 21'h00000A, V ^ 21'h00000A, 1'b1, 1'b1, 8);
        applyStimulus("s0Zero", V ^ 21'h000009, V ^ 21'h000009, 1'b1, 1'b1, 8);

        // Reset in the third SYND cycle; outputs still hold the previous uncorrectable result.
        sendWord(V ^ (21'd3 << 9));
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRst.inReady", 32'(in_ready), 32'd1);
        checkOutput("midRst.outValid", 32'(out_valid), 32'd0);
        checkOutput("midRst.corrected", 32'(corrected), 32'd0);
        checkOutput("midRst.err", 32'(err_detected), 32'd0);
        checkOutput("midRst.unc", 32'(uncorrectable), 32'd0);
        applyStimulus("postRst", V, V, 1'b0, 1'b0, 8);

        // Sink stalls for 5 cycles while a new word waits at the input.
        sendWord(V ^ (21'd5 << 12));
        waitResult("stall", V, 1'b1, 1'b0, 12);
        @(negedge clk);
        codeword = V;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall.outValid", 32'(out_valid), 32'd1);
            checkOutput("stall.corrected", 32'(corrected), 32'(V));
            checkOutput("stall.err", 32'(err_detected), 32'd1);
            checkOutput("stall.unc", 32'(uncorrectable), 32'd0);
            checkOutput("stall.inReady", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("stall.validDrop", 32'(out_valid), 32'd0);
        checkOutput("stall.notYetTaken", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("stall.taken", 32'(in_ready), 32'd0);
        waitResult("afterStall", V, 1'b0, 1'b0, 8);
        drain("afterStall");

        applyStimulus("unc2", V ^ 21'h000009, V ^ 21'h000009, 1'b1, 1'b1, 8);
        applyStimulus("errR4b", V ^ (21'd5 << 12), V, 1'b1, 1'b0, 12);

`ifdef RS_ERR_STATS_EN
        checkOutput("stats.corr", 32'(corr_count), 32'd2);
        checkOutput("stats.uncorr", 32'(uncorr_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
